// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO registers and an IDLE/RUN/FIX FSM
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] p;
  logic [1:0]         op_r;
  logic               neg_q, neg_r;
  logic               sg, sa, sb;
  logic [WIDTH:0]     msum, rtry, rdiff;
  logic [2*WIDTH-1:0] p_next, prod;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign busy = state != IDLE;
  // p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sg     = ~op[0];
    sa     = sg & a[WIDTH-1];
    sb     = sg & b[WIDTH-1];
    msum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mb : {WIDTH{1'b0}})};
    rtry   = p[2*WIDTH-1:WIDTH-1];
    rdiff  = rtry - {1'b0, mb};
    p_next = op_r[1] ? (rdiff[WIDTH] ? {rtry[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
                                     : {rdiff[WIDTH-1:0], p[WIDTH-2:0], 1'b1})
                     : {msum, p[WIDTH-1:1]};
    prod   = neg_q ? -p : p;
    q_fix  = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    r_fix  = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mb    <= '0;
      p     <= '0;
      op_r  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            p     <= {{WIDTH{1'b0}}, (sa ? -a : a)};
            mb    <= sb ? -b : b;
            // a zero divisor must leave the all-ones quotient unnegated
            neg_q <= (sa ^ sb) & (|b);
            neg_r <= sa;
            op_r  <= op;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p     <= p_next;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CW'(WIDTH - 1)) ? FIX : RUN;
        end
        FIX: begin
          {hi, lo} <= op_r[1] ? {r_fix, q_fix} : prod;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, MT writes and reset abort
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic [1:0]  op = '0;
  logic        start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;
  int          total = 0, bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bcyc, output int dcnt);
    @(negedge clk); a = x; b = y; op = o; start = 1'b1;
    @(negedge clk); start = 1'b0;
    bcyc = 0; dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy) bcyc++;
      if (done) dcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
  endtask

  task automatic test_mt;
    @(negedge clk); hi_we = 1'b1; wd = 32'hCAFE;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wd = 32'hBEEF;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi", hi, 32'hCAFE);
    chk("mtlo", lo, 32'hBEEF);
  endtask

  task automatic test_mul;
    int bc, dc;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
    chk("multu_busy_cycles", 32'(bc), 32'd33);
    chk("multu_done_count", 32'(dc), 32'd1);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, bc, dc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    chk("mult_done_count", 32'(dc), 32'd1);
  endtask

  task automatic test_div;
    int bc, dc;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, bc, dc);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'd0, bc, dc);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_busy_cycles", 32'(bc), 32'd33);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, bc, dc);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);
    run_op(2'b11, 32'd100, 32'd7, bc, dc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
  endtask

  task automatic test_mt_with_start;
    @(negedge clk); a = 32'd2; b = 32'd3; op = 2'b01; start = 1'b1; lo_we = 1'b1; wd = 32'h55;
    @(negedge clk); start = 1'b0; lo_we = 1'b0;
    chk("same_edge_mtlo", lo, 32'h55);
    repeat (40) @(negedge clk);
    chk("same_edge_fix_lo", lo, 32'd6);
    chk("same_edge_fix_hi", hi, 32'd0);
  endtask

  task automatic test_back_to_back;
    int bc = 0, dc = 0;
    @(negedge clk); a = 32'd5; b = 32'd6; op = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 5) begin start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3; hi_we = 1'b1; wd = 32'h1234; end
      if (i == 6) begin start = 1'b0; hi_we = 1'b0; end
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
    end
    chk("b2b_busy_cycles", 32'(bc), 32'd33);
    chk("b2b_done_count", 32'(dc), 32'd1);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd30);
  endtask

  task automatic test_reset_abort;
    int bc, dc = 0;
    @(negedge clk); a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dc), 32'd0);
    run_op(2'b01, 32'd3, 32'd4, bc, dc);
    chk("after_abort_lo", lo, 32'd12);
    chk("after_abort_hi", hi, 32'd0);
    chk("after_abort_done_count", 32'(dc), 32'd1);
  endtask

  initial begin
    test_reset;
    test_mt;
    test_mul;
    test_div;
    test_mt_with_start;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
